// File: rtl/alsu_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_secuencial
//  Description : Registered, parametrised arithmetic/logic/shift unit.
//                Result and the four status flags (Acarreo, Desbordamiento,
//                Cero, Negativo) are registered. Multi-bit shifts/rotates run
//                one bit per cycle behind a valid/busy handshake; rotates
//                through carry start from the stored Acarreo.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters  : ANCHO          operand/result width (power of two, >= 4)
//  Ports       : Reloj          clock, rising edge
//                Reiniciar_n    synchronous active-low reset
//                EntradaValida  request, accepted while Ocupado = 0
//                Selector[3:0]  opcode
//                EntradaA/B     operands; EntradaB[ANCHO_CNT-1:0] = shift count
//                Ocupado        iterative shift in progress
//                SalidaValida   one-cycle pulse, result and flags just updated
//                Salida         registered result
//                Acarreo, Desbordamiento, Cero, Negativo   registered flags
//  Config      : define ALSU_BARREL_EN for single-cycle barrel shifts/rotates
//                (Ocupado tied low, no DESPLAZA state).
// ============================================================================
module alsu_secuencial #(
  parameter int ANCHO = 16
) (
  input  logic             Reloj,
  input  logic             Reiniciar_n,
  input  logic             EntradaValida,
  input  logic [3:0]       Selector,
  input  logic [ANCHO-1:0] EntradaA,
  input  logic [ANCHO-1:0] EntradaB,
  output logic             Ocupado,
  output logic             SalidaValida,
  output logic [ANCHO-1:0] Salida,
  output logic             Acarreo,
  output logic             Desbordamiento,
  output logic             Cero,
  output logic             Negativo
);

  localparam int ANCHO_CNT = $clog2(ANCHO);

  localparam logic [3:0] c_op_not  = 4'b0000;
  localparam logic [3:0] c_op_and  = 4'b0001;
  localparam logic [3:0] c_op_xor  = 4'b0010;
  localparam logic [3:0] c_op_or   = 4'b0011;
  localparam logic [3:0] c_op_dec  = 4'b0100;
  localparam logic [3:0] c_op_add  = 4'b0101;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_inc  = 4'b0111;
  localparam logic [3:0] c_op_mov  = 4'b1000;
  localparam logic [3:0] c_op_rlc  = 4'b1001;
  localparam logic [3:0] c_op_test = 4'b1010;
  localparam logic [3:0] c_op_rrc  = 4'b1011;
  localparam logic [3:0] c_op_sl   = 4'b1100;
  localparam logic [3:0] c_op_rl   = 4'b1101;
  localparam logic [3:0] c_op_sr   = 4'b1110;
  localparam logic [3:0] c_op_rr   = 4'b1111;

  localparam logic [ANCHO:0] c_uno = {{ANCHO{1'b0}}, 1'b1};
  localparam int             c_msb = ANCHO - 1;

  // One shift/rotate step on the packed pair {carry, value}.
  function automatic logic [ANCHO:0] f_paso(input logic [3:0] op, input logic [ANCHO:0] cr);
    logic             c;
    logic [ANCHO-1:0] r;
    c = cr[ANCHO];
    r = cr[ANCHO-1:0];
    case (op)
      c_op_sl: f_paso = {r[ANCHO-1], r[ANCHO-2:0], 1'b0};
      c_op_rl: f_paso = {r[ANCHO-1], r[ANCHO-2:0], r[ANCHO-1]};
      c_op_sr: f_paso = {r[0], 1'b0, r[ANCHO-1:1]};
      c_op_rr: f_paso = {r[0], r[0], r[ANCHO-1:1]};
      c_op_rlc: f_paso = {r[ANCHO-1], r[ANCHO-2:0], c};
      c_op_rrc: f_paso = {r[0], c, r[ANCHO-1:1]};
      default: f_paso = cr;
    endcase
  endfunction

  logic [ANCHO-1:0] r_salida;
  logic             r_c;
  logic             r_v;
  logic             r_z;
  logic             r_n;
  logic             r_valida;

  logic [ANCHO:0]     w_suma;
  logic [ANCHO:0]     w_resta;
  logic [ANCHO:0]     w_inc;
  logic [ANCHO:0]     w_dec;
  logic [ANCHO-1:0]   w_res;
  logic [ANCHO-1:0]   w_zn;
  logic               w_c;
  logic               w_v;
  logic [ANCHO_CNT-1:0] w_cnt_pedido;

  // Write-back selection, shared by both build variants.
  logic             w_escribe;
  logic [ANCHO-1:0] w_nres;
  logic [ANCHO-1:0] w_nzn;
  logic             w_nc;
  logic             w_nv;

  assign w_cnt_pedido = EntradaB[ANCHO_CNT-1:0];

`ifdef ALSU_BARREL_EN
  // Unrolled chain of single steps: bit-exact with the iterative unit.
  function automatic logic [ANCHO:0] f_barrel(input logic [3:0] op, input logic [ANCHO:0] cr,
                                              input logic [ANCHO_CNT-1:0] n);
    logic [ANCHO:0] t;
    t = cr;
    for (int i = 0; i < ANCHO - 1; i++) begin
      if (i < int'(n)) t = f_paso(op, t);
    end
    f_barrel = t;
  endfunction

  logic [ANCHO:0] w_barrel;
  assign w_barrel = f_barrel(Selector, {r_c, EntradaA}, w_cnt_pedido);
`endif

  // Single-cycle datapath (also the n = 0 shift path in the iterative build).
  always_comb begin
    w_suma  = {1'b0, EntradaA} + {1'b0, EntradaB};
    w_resta = {1'b0, EntradaA} - {1'b0, EntradaB};
    w_inc   = {1'b0, EntradaA} + c_uno;
    w_dec   = {1'b0, EntradaA} - c_uno;
    w_res   = r_salida;
    w_c     = r_c;
    w_v     = r_v;
    case (Selector)
      c_op_not: w_res = ~EntradaA;
      c_op_and: w_res = EntradaA & EntradaB;
      c_op_xor: w_res = EntradaA ^ EntradaB;
      c_op_or:  w_res = EntradaA | EntradaB;
      c_op_mov: w_res = EntradaA;
      c_op_dec: begin
        w_res = w_dec[ANCHO-1:0];
        w_c   = w_dec[ANCHO];
        w_v   = EntradaA[c_msb] && !w_dec[c_msb];
      end
      c_op_add: begin
        w_res = w_suma[ANCHO-1:0];
        w_c   = w_suma[ANCHO];
        w_v   = (EntradaA[c_msb] == EntradaB[c_msb]) && (w_suma[c_msb] != EntradaA[c_msb]);
      end
      c_op_sub, c_op_test: begin
        if (Selector == c_op_sub) w_res = w_resta[ANCHO-1:0];
        w_c = w_resta[ANCHO];
        w_v = (EntradaA[c_msb] != EntradaB[c_msb]) && (w_resta[c_msb] != EntradaA[c_msb]);
      end
      c_op_inc: begin
        w_res = w_inc[ANCHO-1:0];
        w_c   = w_inc[ANCHO];
        w_v   = !EntradaA[c_msb] && w_inc[c_msb];
      end
      c_op_rlc, c_op_rrc, c_op_sl, c_op_rl, c_op_sr, c_op_rr: begin
`ifdef ALSU_BARREL_EN
        w_res = w_barrel[ANCHO-1:0];
        w_c   = w_barrel[ANCHO];
`else
        // Only reaches write-back when n = 0: result is A, carry holds.
        w_res = EntradaA;
`endif
      end
      default: w_res = r_salida;
    endcase
    // TEST leaves Salida alone but flags Z/N from the difference.
    w_zn = (Selector == c_op_test) ? w_resta[ANCHO-1:0] : w_res;
  end

`ifdef ALSU_BARREL_EN
  assign Ocupado   = 1'b0;
  assign w_escribe = EntradaValida;
  assign w_nres    = w_res;
  assign w_nzn     = w_zn;
  assign w_nc      = w_c;
  assign w_nv      = w_v;
`else
  typedef enum logic [0:0] {
    LIBRE    = 1'b0,
    DESPLAZA = 1'b1
  } estado_t;

  localparam logic [ANCHO_CNT-1:0] c_cnt_uno = {{(ANCHO_CNT-1){1'b0}}, 1'b1};

  estado_t              r_estado;
  estado_t              w_estado_sig;
  logic [ANCHO-1:0]     r_trab;
  logic                 r_cw;
  logic [ANCHO_CNT-1:0] r_cnt;
  logic [3:0]           r_op;
  logic [ANCHO:0]       w_paso;
  logic                 w_acepta;
  logic                 w_arranca;
  logic                 w_fin_desp;

  assign w_acepta   = (r_estado == LIBRE) && EntradaValida;
  assign w_arranca  = Selector[3] && (Selector[2] || Selector[0]) && (w_cnt_pedido != '0);
  assign w_paso     = f_paso(r_op, {r_cw, r_trab});
  assign w_fin_desp = (r_estado == DESPLAZA) && (r_cnt == c_cnt_uno);
  assign Ocupado    = (r_estado == DESPLAZA);

  always_ff @(posedge Reloj) begin
    if (!Reiniciar_n) r_estado <= LIBRE;
    else              r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      LIBRE:    if (w_acepta && w_arranca) w_estado_sig = DESPLAZA;
      DESPLAZA: if (w_fin_desp)            w_estado_sig = LIBRE;
      default:  w_estado_sig = LIBRE;
    endcase
  end

  // Working copy of the value and carry; architectural flags stay put
  // until the final step.
  always_ff @(posedge Reloj) begin
    if (!Reiniciar_n) begin
      r_trab <= '0;
      r_cw   <= 1'b0;
      r_cnt  <= '0;
      r_op   <= '0;
    end else if (w_acepta && w_arranca) begin
      r_trab <= EntradaA;
      r_cw   <= r_c;
      r_cnt  <= w_cnt_pedido;
      r_op   <= Selector;
    end else if (r_estado == DESPLAZA) begin
      {r_cw, r_trab} <= w_paso;
      r_cnt          <= r_cnt - c_cnt_uno;
    end
  end

  assign w_escribe = w_fin_desp || (w_acepta && !w_arranca);
  assign w_nres    = w_fin_desp ? w_paso[ANCHO-1:0] : w_res;
  assign w_nzn     = w_fin_desp ? w_paso[ANCHO-1:0] : w_zn;
  assign w_nc      = w_fin_desp ? w_paso[ANCHO]     : w_c;
  assign w_nv      = w_fin_desp ? r_v               : w_v;
`endif

  always_ff @(posedge Reloj) begin
    if (!Reiniciar_n) begin
      r_salida <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_valida <= 1'b0;
    end else begin
      r_valida <= 1'b0;
      if (w_escribe) begin
        r_salida <= w_nres;
        r_c      <= w_nc;
        r_v      <= w_nv;
        r_z      <= (w_nzn == '0);
        r_n      <= w_nzn[c_msb];
        r_valida <= 1'b1;
      end
    end
  end

  assign Salida         = r_salida;
  assign Acarreo        = r_c;
  assign Desbordamiento = r_v;
  assign Cero           = r_z;
  assign Negativo       = r_n;
  assign SalidaValida   = r_valida;

endmodule
`default_nettype wire

// File: tb/tb_alsu_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alsu_secuencial
//  Description : Scoreboard bench for alsu_secuencial (ANCHO = 16). A driver
//                issues directed and random requests, a reference model
//                predicts result/flags/latency and queues them; a monitor pops
//                and compares on every SalidaValida and tracks Ocupado.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alsu_secuencial;

`ifdef ALSU_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        Reloj = 1'b0;
  logic        Reiniciar_n = 1'b0;
  logic        EntradaValida = 1'b0;
  logic [3:0]  Selector = '0;
  logic [15:0] EntradaA = '0;
  logic [15:0] EntradaB = '0;
  logic        Ocupado;
  logic        SalidaValida;
  logic [15:0] Salida;
  logic        Acarreo, Desbordamiento, Cero, Negativo;

  alsu_secuencial #(.ANCHO(16)) dut (
    .Reloj(Reloj), .Reiniciar_n(Reiniciar_n), .EntradaValida(EntradaValida),
    .Selector(Selector), .EntradaA(EntradaA), .EntradaB(EntradaB),
    .Ocupado(Ocupado), .SalidaValida(SalidaValida), .Salida(Salida),
    .Acarreo(Acarreo), .Desbordamiento(Desbordamiento), .Cero(Cero), .Negativo(Negativo)
  );

  always #5 Reloj = ~Reloj;

  typedef struct {
    logic [15:0] res;
    logic        c, v, z, neg;
    int          lat;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        cola[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          busy_lo = 0;
  int          busy_hi = 0;
  int          last_done = 0;
  bit          mon_en  = 1'b0;
  logic [15:0] m_sal = '0;
  logic        m_c = 1'b0;
  logic        m_v = 1'b0;

  always @(posedge Reloj) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: whole-operation arithmetic, not step-by-step.
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output exp_t e);
    int          sa, sbv, r, n;
    logic [63:0] x, t;
    logic [15:0] zn;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    n   = int'(b[3:0]);
    e.res = m_sal; e.c = m_c; e.v = m_v; e.lat = 0; e.cyc = 0; e.nm = "";
    zn = '0;
    case (op)
      4'h0: e.res = ~a;
      4'h1: e.res = a & b;
      4'h2: e.res = a ^ b;
      4'h3: e.res = a | b;
      4'h8: e.res = a;
      4'h4: begin e.res = a - 16'd1; e.c = (a == 16'd0); r = sa - 1; e.v = (r < -32768); end
      4'h5: begin
        e.res = a + b; e.c = (int'(a) + int'(b) > 65535);
        r = sa + sbv; e.v = (r > 32767) || (r < -32768);
      end
      4'h6, 4'hA: begin
        zn = a - b; e.c = (a < b);
        r = sa - sbv; e.v = (r > 32767) || (r < -32768);
        if (op == 4'h6) e.res = zn;
      end
      4'h7: begin e.res = a + 16'd1; e.c = (a == 16'hFFFF); r = sa + 1; e.v = (r > 32767); end
      default: begin
        x = 64'(a);
        case (op)
          4'hC: begin t = x << n; e.res = t[15:0]; if (n > 0) e.c = t[16]; end
          4'hD: begin t = (x << n) | (x >> (16 - n)); e.res = t[15:0]; if (n > 0) e.c = t[0]; end
          4'hE: begin t = x >> n; e.res = t[15:0]; if (n > 0) e.c = a[n-1]; end
          4'hF: begin t = (x >> n) | (x << (16 - n)); e.res = t[15:0]; if (n > 0) e.c = t[15]; end
          4'h9: begin
            x = {47'b0, m_c, a};
            t = ((x << n) | (x >> (17 - n))) & 64'h1FFFF;
            e.res = t[15:0]; e.c = t[16];
          end
          default: begin
            x = {47'b0, a, m_c};
            t = ((x >> n) | (x << (17 - n))) & 64'h1FFFF;
            e.res = t[16:1]; e.c = t[0];
          end
        endcase
        e.lat = BARREL ? 0 : n;
      end
    endcase
    if (op != 4'hA) zn = e.res;
    e.z = (zn == 16'd0);
    e.neg = zn[15];
    m_sal = e.res; m_c = e.c; m_v = e.v;
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input string nm);
    exp_t e;
    Selector = op; EntradaA = a; EntradaB = b; EntradaValida = 1'b1;
    @(posedge Reloj); #1;
    EntradaValida = 1'b0;
    model(op, a, b, e);
    e.cyc = cyc + e.lat;
    e.nm  = nm;
    if (e.lat > 0) begin busy_lo = cyc; busy_hi = cyc + e.lat; end
    cola.push_back(e);
    last_done = e.cyc;
  endtask

  task automatic wait_done();
    while (cyc < last_done) begin @(posedge Reloj); #1; end
  endtask

  always @(negedge Reloj) begin
    if (mon_en) begin
      chk("ocupado", {31'b0, Ocupado}, {31'b0, (cyc >= busy_lo) && (cyc < busy_hi)});
      if (SalidaValida !== 1'b0) begin
        if (cola.size() == 0) begin
          chk("valida_espuria", {31'b0, SalidaValida}, 32'd0);
        end else begin
          exp_t e;
          e = cola.pop_front();
          chk({e.nm, " latencia"}, cyc, e.cyc);
          chk({e.nm, " salida"}, {16'b0, Salida}, {16'b0, e.res});
          chk({e.nm, " flags_CVZN"}, {28'b0, Acarreo, Desbordamiento, Cero, Negativo},
              {28'b0, e.c, e.v, e.z, e.neg});
        end
      end else if (cola.size() > 0 && cyc > cola[0].cyc) begin
        chk({cola[0].nm, " sin_valida"}, {31'b0, SalidaValida}, 32'd1);
        void'(cola.pop_front());
      end
    end
  end

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reiniciar_n = 1'b0;
    repeat (3) begin @(posedge Reloj); #1; end
    Reiniciar_n = 1'b1;
    chk("reset salida", {16'b0, Salida}, 32'd0);
    chk("reset flags_CVZN", {28'b0, Acarreo, Desbordamiento, Cero, Negativo}, 32'd0);
    chk("reset valida_ocupado", {30'b0, SalidaValida, Ocupado}, 32'd0);
    mon_en = 1'b1;

    send(4'h5, 16'h7FFF, 16'h0001, "add_ovf");  wait_done();
    send(4'h6, 16'h0000, 16'h0001, "sub_borrow"); wait_done();
    send(4'hA, 16'h1234, 16'h1234, "test_eq");  wait_done();
    send(4'h1, 16'h00F0, 16'h0F00, "and_zero"); wait_done();

    // SL by 5 with a request presented while busy; it must be ignored.
    send(4'hC, 16'h0001, 16'h0005, "sl5");
    if (!BARREL) begin
      Selector = 4'h5; EntradaA = 16'h1111; EntradaB = 16'h2222; EntradaValida = 1'b1;
      repeat (2) begin @(posedge Reloj); #1; end
      EntradaValida = 1'b0;
    end
    wait_done();

    send(4'h6, 16'h0000, 16'h0001, "sub_setc"); wait_done();
    send(4'h9, 16'h8000, 16'h0001, "rlcy1");    wait_done();
    send(4'hB, 16'h0001, 16'h0001, "rrcy1");    wait_done();
    send(4'hF, 16'h0001, 16'h000F, "rr15");     wait_done();

    // Reset during the third busy cycle of SR by 10; a request held during
    // reset must be discarded.
    send(4'hE, 16'hFFFF, 16'h000A, "sr10");
    repeat (2) begin @(posedge Reloj); #1; end
    Reiniciar_n = 1'b0;
    Selector = 4'h7; EntradaA = 16'hFFFF; EntradaValida = 1'b1;
    @(posedge Reloj); #1;
    Reiniciar_n = 1'b1; EntradaValida = 1'b0;
    cola.delete();
    m_sal = '0; m_c = 1'b0; m_v = 1'b0;
    busy_hi = cyc;
    last_done = cyc;
    chk("midreset salida", {16'b0, Salida}, 32'd0);
    chk("midreset flags_CVZN", {28'b0, Acarreo, Desbordamiento, Cero, Negativo}, 32'd0);
    chk("midreset valida_ocupado", {30'b0, SalidaValida, Ocupado}, 32'd0);
    @(posedge Reloj); #1;
    send(4'h7, 16'hFFFF, 16'h0000, "inc_wrap"); wait_done();

    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      send(op, rnd_val(), rnd_val(), $sformatf("rnd%0d_op%0h", i, op));
      wait_done();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge Reloj); #1; end
    end

    repeat (5) begin @(posedge Reloj); #1; end
    chk("cola_vacia", cola.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
